// File: rtl/fft_pkg.sv
// Shared constants, FSM states and helpers for the radix-2 FFT address sequencer.
package fft_pkg;

  localparam int unsigned LOG2N_MAX_DEF = 6;
  localparam int unsigned RD_LAT        = 1;
  // Must track the pipeline depth of butterfly_radix2.
  localparam int unsigned BF_LAT        = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_e;

  // Requested size folded into the supported range 1..vmax.
  function automatic int unsigned clamp_log2n(input int unsigned v, input int unsigned vmax);
    if (v == 0) return 1;
    if (v > vmax) return vmax;
    return v;
  endfunction

endpackage

// File: rtl/fft_bf_addr_gen_if.sv
// Control/address bundle between the FFT sequencer, working memory, twiddle ROM and butterfly.
interface fft_bf_addr_gen_if
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N_MAX = LOG2N_MAX_DEF
);
  localparam int unsigned LW = $clog2(LOG2N_MAX + 1);
  localparam int unsigned AW = LOG2N_MAX;
  localparam int unsigned TW = LOG2N_MAX - 1;
  localparam int unsigned SW = $clog2(LOG2N_MAX);

  logic          start;
  logic [LW-1:0] log2n;
  logic          busy;
  logic          done;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic          rd_en;
  logic [TW-1:0] tw_addr;
  logic          bf_enable;
  logic          wr_en;
  logic [AW-1:0] wr_addr_a;
  logic [AW-1:0] wr_addr_b;
  logic [SW-1:0] stage_idx;

  modport master (
    output start, log2n,
    input  busy, done, rd_addr_a, rd_addr_b, rd_en, tw_addr,
           bf_enable, wr_en, wr_addr_a, wr_addr_b, stage_idx
  );

  modport slave (
    input  start, log2n,
    output busy, done, rd_addr_a, rd_addr_b, rd_en, tw_addr,
           bf_enable, wr_en, wr_addr_a, wr_addr_b, stage_idx
  );

endinterface

// File: rtl/fft_pipe_delay.sv
// Fixed-depth shift register with asynchronous active-high clear.
module fft_pipe_delay #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < int'(DEPTH); i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/fft_bf_addr_gen.sv
// In-place radix-2 DIT stage/butterfly sequencer: read, twiddle and aligned write-back addresses.
module fft_bf_addr_gen
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N_MAX = LOG2N_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  fft_bf_addr_gen_if.slave  bus
);

  localparam int unsigned AW        = LOG2N_MAX;
  localparam int unsigned TW        = LOG2N_MAX - 1;
  localparam int unsigned KW        = LOG2N_MAX - 1;
  localparam int unsigned LW        = $clog2(LOG2N_MAX + 1);
  localparam int unsigned SW        = $clog2(LOG2N_MAX);
  localparam int unsigned DRAIN_LEN = RD_LAT + BF_LAT;
  localparam int unsigned DW        = $clog2(DRAIN_LEN + 1);
  localparam int unsigned WW        = 1 + 2 * AW;

  state_e        state_q, state_d;
  logic [LW-1:0] l_q, l_d;
  logic [SW-1:0] s_q, s_d;
  logic [KW-1:0] k_q, k_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rd_en_q, rd_en_d;
  logic [AW-1:0] rd_addr_a_q, rd_addr_a_d;
  logic [AW-1:0] rd_addr_b_q, rd_addr_b_d;
  logic [TW-1:0] tw_addr_q, tw_addr_d;
  logic [SW-1:0] stage_q, stage_d;

  logic [AW-1:0] span_c, j_c, grp_c, a_c, b_c;
  logic [SW-1:0] tw_sh_c, s_last_c;
  logic [TW-1:0] tw_c;
  logic [KW-1:0] k_last_c;

  // Butterfly k of stage s: pair (a, a+2^s) inside group k>>s.
  always_comb begin
    span_c   = AW'(1) << s_q;
    j_c      = AW'(k_q) & (span_c - AW'(1));
    grp_c    = AW'(k_q) >> s_q;
    a_c      = ((grp_c << s_q) << 1) | j_c;
    b_c      = a_c + span_c;
    tw_sh_c  = SW'(TW) - s_q;
    tw_c     = TW'(j_c << tw_sh_c);
    k_last_c = KW'((AW'(1) << (l_q - LW'(1))) - AW'(1));
    s_last_c = SW'(l_q - LW'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    l_d         = l_q;
    s_d         = s_q;
    k_d         = k_q;
    dcnt_d      = dcnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rd_en_d     = 1'b0;
    rd_addr_a_d = '0;
    rd_addr_b_d = '0;
    tw_addr_d   = '0;
    stage_d     = stage_q;
    unique case (state_q)
      IDLE: begin
        // A visible done pulse still belongs to the finishing run; start is not taken then.
        if (bus.start && !done_q) begin
          l_d     = LW'(clamp_log2n(32'(bus.log2n), LOG2N_MAX));
          s_d     = '0;
          k_d     = '0;
          dcnt_d  = '0;
          busy_d  = 1'b1;
          stage_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        rd_en_d     = 1'b1;
        rd_addr_a_d = a_c;
        rd_addr_b_d = b_c;
        tw_addr_d   = tw_c;
        stage_d     = s_q;
        if (k_q == k_last_c) begin
          dcnt_d  = '0;
          state_d = DRAIN;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DRAIN: begin
        // Let every write of this stage land before the next stage reads in place.
        if (dcnt_q == DW'(DRAIN_LEN - 1)) begin
          if (s_q == s_last_c) begin
            state_d = FINISH;
          end else begin
            s_d     = s_q + SW'(1);
            k_d     = '0;
            state_d = ISSUE;
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        stage_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_q         <= '0;
      s_q         <= '0;
      k_q         <= '0;
      dcnt_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      tw_addr_q   <= '0;
      stage_q     <= '0;
    end else begin
      l_q         <= l_d;
      s_q         <= s_d;
      k_q         <= k_d;
      dcnt_q      <= dcnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      tw_addr_q   <= tw_addr_d;
      stage_q     <= stage_d;
    end
  end

  logic          bf_en_q;
  logic [WW-1:0] wr_q;

  fft_pipe_delay #(.DEPTH(RD_LAT), .WIDTH(1)) u_bf_dly (
    .clk (clk),
    .rst (rst),
    .d_i (rd_en_q),
    .q_o (bf_en_q)
  );

  fft_pipe_delay #(.DEPTH(DRAIN_LEN), .WIDTH(WW)) u_wr_dly (
    .clk (clk),
    .rst (rst),
    .d_i ({rd_en_q, rd_addr_a_q, rd_addr_b_q}),
    .q_o (wr_q)
  );

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr_a = rd_addr_a_q;
  assign bus.rd_addr_b = rd_addr_b_q;
  assign bus.tw_addr   = tw_addr_q;
  assign bus.stage_idx = stage_q;
  assign bus.bf_enable = bf_en_q;
  assign {bus.wr_en, bus.wr_addr_a, bus.wr_addr_b} = wr_q;

endmodule

// File: tb/tb_fft_bf_addr_gen.sv
// Directed bench for fft_bf_addr_gen at LOG2N_MAX=4: sequence, timing, clamping and reset abort.
module tb_fft_bf_addr_gen;
  import fft_pkg::*;

  localparam int unsigned LMAX = 4;
  localparam int unsigned AW   = 4;
  localparam int unsigned TW   = 3;
  localparam int unsigned LW   = 3;
  localparam int unsigned SW   = 2;
  localparam int          DLY  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_bf_addr_gen_if #(.LOG2N_MAX(LMAX)) bus ();

  fft_bf_addr_gen #(.LOG2N_MAX(LMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int obs_a[$];
  int obs_b[$];
  int obs_t[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full run of one transform, compared cycle by cycle against an independent loop-nest model.
  task automatic run_xform(input int ln, input int exp_l, input bit hold_start, input string tag);
    int m, tot, wr_cnt, rd_cnt, prev_stage;
    bit e_rd [128];
    int e_a [128];
    int e_b [128];
    int e_t [128];
    int e_s [128];
    m   = 1 << (exp_l - 1);
    tot = exp_l * (m + DLY) + 2;
    for (int i = 0; i < 128; i++) begin
      e_rd[i] = 1'b0; e_a[i] = 0; e_b[i] = 0; e_t[i] = 0; e_s[i] = 0;
    end
    for (int s = 0; s < exp_l; s++) begin
      int span, k;
      span = 1 << s;
      k = 0;
      for (int base = 0; base < (1 << exp_l); base += 2 * span) begin
        for (int j = 0; j < span; j++) begin
          int c;
          c = 2 + s * (m + DLY) + k;
          e_rd[c] = 1'b1;
          e_a[c]  = base + j;
          e_b[c]  = base + j + span;
          e_t[c]  = j << (LMAX - 1 - s);
          e_s[c]  = s;
          k++;
        end
      end
    end
    obs_a.delete(); obs_b.delete(); obs_t.delete();
    wr_cnt = 0; rd_cnt = 0; prev_stage = -1;

    bus.start = 1'b1;
    bus.log2n = LW'(ln);
    tick();
    if (!hold_start) bus.start = 1'b0;

    for (int n = 1; n <= tot + 4; n++) begin
      if (n > 1) tick();
      if (hold_start && n == tot - 2) bus.start = 1'b0;
      if (hold_start && n == tot)     bus.start = 1'b1;
      if (hold_start && n == tot + 1) bus.start = 1'b0;

      checks++;
      if (bus.busy !== (n < tot)) begin
        errors++; $display("FAIL %s busy cyc=%0d got=%b exp=%b", tag, n, bus.busy, (n < tot));
      end
      checks++;
      if (bus.done !== (n == tot)) begin
        errors++; $display("FAIL %s done cyc=%0d got=%b exp=%b", tag, n, bus.done, (n == tot));
      end
      checks++;
      if (bus.rd_en !== e_rd[n]) begin
        errors++; $display("FAIL %s rd_en cyc=%0d got=%b exp=%b", tag, n, bus.rd_en, e_rd[n]);
      end
      checks++;
      if (bus.bf_enable !== e_rd[n-1]) begin
        errors++; $display("FAIL %s bf_enable cyc=%0d got=%b exp=%b", tag, n, bus.bf_enable, e_rd[n-1]);
      end
      checks++;
      if (bus.wr_en !== ((n >= 4) ? e_rd[n-3] : 1'b0)) begin
        errors++; $display("FAIL %s wr_en cyc=%0d got=%b exp=%b", tag, n, bus.wr_en, (n >= 4) ? e_rd[n-3] : 1'b0);
      end
      if (e_rd[n]) begin
        checks++;
        if (bus.rd_addr_a !== AW'(e_a[n]) || bus.rd_addr_b !== AW'(e_b[n]) ||
            bus.tw_addr !== TW'(e_t[n]) || bus.stage_idx !== SW'(e_s[n])) begin
          errors++;
          $display("FAIL %s rd_addr cyc=%0d got a=%0d b=%0d tw=%0d st=%0d exp a=%0d b=%0d tw=%0d st=%0d",
                   tag, n, bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr, bus.stage_idx,
                   e_a[n], e_b[n], e_t[n], e_s[n]);
        end
        obs_a.push_back(int'(bus.rd_addr_a));
        obs_b.push_back(int'(bus.rd_addr_b));
        obs_t.push_back(int'(bus.tw_addr));
      end
      if (n >= 4 && e_rd[n-3]) begin
        checks++;
        if (bus.wr_addr_a !== AW'(e_a[n-3]) || bus.wr_addr_b !== AW'(e_b[n-3])) begin
          errors++;
          $display("FAIL %s wr_addr cyc=%0d got a=%0d b=%0d exp a=%0d b=%0d",
                   tag, n, bus.wr_addr_a, bus.wr_addr_b, e_a[n-3], e_b[n-3]);
        end
      end
      // First read of a new stage must find every earlier write already issued.
      if (bus.rd_en === 1'b1) begin
        if (prev_stage >= 0 && int'(bus.stage_idx) != prev_stage) begin
          checks++;
          if (rd_cnt != wr_cnt) begin
            errors++; $display("FAIL %s hazard cyc=%0d reads=%0d writes=%0d", tag, n, rd_cnt, wr_cnt);
          end
        end
        prev_stage = int'(bus.stage_idx);
        rd_cnt++;
      end
      if (bus.wr_en === 1'b1) wr_cnt++;
    end
    checks++;
    if (wr_cnt != exp_l * m) begin
      errors++; $display("FAIL %s wr_count got=%0d exp=%0d", tag, wr_cnt, exp_l * m);
    end
  endtask

  task automatic test_reset;
    logic [25:0] outs;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.log2n = '0;
    repeat (3) tick();
    outs = {bus.busy, bus.done, bus.rd_en, bus.bf_enable, bus.wr_en, bus.rd_addr_a, bus.rd_addr_b,
            bus.tw_addr, bus.wr_addr_a, bus.wr_addr_b, bus.stage_idx};
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", outs);
    end
    rst = 1'b0;
    repeat (2) tick();
    outs = {bus.busy, bus.done, bus.rd_en, bus.bf_enable, bus.wr_en, bus.rd_addr_a, bus.rd_addr_b,
            bus.tw_addr, bus.wr_addr_a, bus.wr_addr_b, bus.stage_idx};
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL idle_outputs got=%h exp=0", outs);
    end
  endtask

  task automatic test_basic;
    int ha [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int hb [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int ht [12] = '{0, 0, 0, 0, 0, 4, 0, 4, 0, 2, 4, 6};
    run_xform(3, 3, 1'b0, "l3");
    checks++;
    if (obs_a.size() != 12) begin
      errors++; $display("FAIL l3_count got=%0d exp=12", obs_a.size());
    end
    for (int i = 0; i < 12 && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i] != ha[i] || obs_b[i] != hb[i] || obs_t[i] != ht[i]) begin
        errors++;
        $display("FAIL l3_table idx=%0d got (%0d,%0d,%0d) exp (%0d,%0d,%0d)",
                 i, obs_a[i], obs_b[i], obs_t[i], ha[i], hb[i], ht[i]);
      end
    end
  endtask

  task automatic test_cycle_count;
    run_xform(4, 4, 1'b0, "l4");
  endtask

  task automatic test_clamp;
    run_xform(0, 1, 1'b1, "l0");
    checks++;
    if (obs_a.size() != 1 || obs_a[0] != 0 || obs_b[0] != 1 || obs_t[0] != 0) begin
      errors++;
      $display("FAIL l0_single got n=%0d a=%0d b=%0d exp n=1 a=0 b=1",
               obs_a.size(), (obs_a.size() > 0) ? obs_a[0] : -1, (obs_b.size() > 0) ? obs_b[0] : -1);
    end
    run_xform(7, 4, 1'b1, "l7");
  endtask

  task automatic test_reset_abort;
    logic [25:0] outs;
    bit found;
    found = 1'b0;
    bus.start = 1'b1;
    bus.log2n = LW'(3);
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.rd_en === 1'b1 && bus.stage_idx === SW'(1)) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL abort_reach_stage1 got=0 exp=1");
    end
    #2;
    rst = 1'b1;
    #1;
    outs = {bus.busy, bus.done, bus.rd_en, bus.bf_enable, bus.wr_en, bus.rd_addr_a, bus.rd_addr_b,
            bus.tw_addr, bus.wr_addr_a, bus.wr_addr_b, bus.stage_idx};
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL abort_outputs got=%h exp=0", outs);
    end
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++;
      if (bus.wr_en !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet cyc=%0d got wr=%b done=%b busy=%b exp 0", i, bus.wr_en, bus.done, bus.busy);
      end
    end
    run_xform(3, 3, 1'b0, "after_rst");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_cycle_count();
    test_clamp();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
